// File: rtl/frame_buffer_reader_if.sv
// frame_buffer_reader_if: SRAM read port plus flow-controlled pixel stream.
// master = reader (addr/rden/pix_* out), slave = SRAM model and pixel consumer.
interface frame_buffer_reader_if;
  logic [17:0] addr;
  logic        rden;
  logic [31:0] rd_data;
  logic [31:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x;
  logic [7:0]  pix_y;
  logic        pix_sof;
  logic        pix_eol;

  modport master (
    output addr, rden,
    output pix_data, pix_valid,
    output pix_x, pix_y,
    output pix_sof, pix_eol,
    input  rd_data, pix_ready
  );

  modport slave (
    input  addr, rden,
    input  pix_data, pix_valid,
    input  pix_x, pix_y,
    input  pix_sof, pix_eol,
    output rd_data, pix_ready
  );
endinterface

// File: rtl/frame_buffer_reader.sv
// frame_buffer_reader: scans one WIDTHxHEIGHT frame out of SRAM into a pixel stream.
// Ports: clk, reset (async high), pause, enable, starting_address, bus (SRAM read +
// pixel stream, master modport), done, mismatch_count. Optional pattern
// checker: define FRAME_READER_CHECK_EN, otherwise mismatch_count is tied to 0.
module frame_buffer_reader #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  enable,
  input  logic [17:0]           starting_address,
  frame_buffer_reader_if.master bus,
  output logic                  done,
  output logic [16:0]           mismatch_count
);

  localparam int TOTAL = WIDTH * HEIGHT;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int NW    = AW + 1;
  localparam int CW    = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    DONE,
    CLEANUP
  } state_t;

  state_t state, state_n;

  logic [16:0]           issue_idx;
  logic [RD_LATENCY-1:0] vld;
  logic [31:0]           mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [NW-1:0]         count;
  logic [8:0]            x;
  logic [7:0]            y;
  logic [CW-1:0]         inflight;
  logic                  issue, push, pop, credit;
  logic                  last_issue, last_pix;

  assign bus.pix_valid = (count != '0) && !pause;
  assign bus.pix_data  = mem[rd_ptr];
  assign bus.pix_x     = x;
  assign bus.pix_y     = y;
  // Markers gated by valid so they read 0 while nothing is presented.
  assign bus.pix_sof   = bus.pix_valid && (x == '0) && (y == '0);
  assign bus.pix_eol   = bus.pix_valid && (x == 9'(WIDTH - 1));

  assign pop  = bus.pix_valid && bus.pix_ready;
  assign push = vld[RD_LATENCY-1];

  // Reads in flight (strobe register plus return pipe) and FIFO words that
  // survive this cycle's pop. Counting the pop lets a full-rate stream keep
  // issuing while the total can never exceed FIFO_DEPTH.
  always_comb begin
    inflight = CW'(bus.rden);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(vld[i]);
    end
    inflight = inflight + CW'(count) - CW'(pop);
  end

  assign credit     = inflight < CW'(FIFO_DEPTH);
  assign issue      = (state == READ) && !pause && credit;
  assign last_issue = issue && (issue_idx == 17'(TOTAL - 1));
  assign last_pix   = pop && (x == 9'(WIDTH - 1)) && (y == 8'(HEIGHT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable && !pause) state_n = READ;
      READ:    if (last_issue) state_n = DRAIN;
      DRAIN:   if (last_pix) state_n = DONE;
      DONE:    state_n = CLEANUP;
      CLEANUP: if (!enable) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state_n == DONE) || (state_n == CLEANUP);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rden  <= 1'b0;
      bus.addr  <= '0;
      issue_idx <= '0;
    end else begin
      bus.rden <= issue;
      bus.addr <= issue ? starting_address + 18'(issue_idx) : '0;
      if (state == IDLE)  issue_idx <= '0;
      else if (issue)     issue_idx <= issue_idx + 17'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
    end else begin
      vld[0] <= bus.rden;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.rd_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(push) - NW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (state == IDLE) begin
      x <= '0;
      y <= '0;
    end else if (pop) begin
      if (x == 9'(WIDTH - 1)) begin
        x <= '0;
        y <= (y == 8'(HEIGHT - 1)) ? '0 : y + 8'd1;
      end else begin
        x <= x + 9'd1;
      end
    end
  end

`ifdef FRAME_READER_CHECK_EN
  logic [16:0] out_idx;
  logic [17:0] exp_addr;
  logic [31:0] exp_word;

  assign exp_addr = starting_address + 18'(out_idx);
  assign exp_word = {6'd0, exp_addr, 8'h00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_idx        <= '0;
      mismatch_count <= '0;
    end else if (state == IDLE) begin
      out_idx        <= '0;
      mismatch_count <= '0;
    end else if (pop) begin
      out_idx <= out_idx + 17'd1;
      if ((bus.pix_data != exp_word) && (mismatch_count != '1)) begin
        mismatch_count <= mismatch_count + 17'd1;
      end
    end
  end
`else
  assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_reader.sv
// tb_frame_buffer_reader: directed bench for frame_buffer_reader on a small 8x4 frame.
// Latency-2 SRAM model returns a {addr, 8'h00} gradient with optional corrupt words.
module tb_frame_buffer_reader;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int L     = 2;
  localparam int D     = 4;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        pause;
  logic        enable;
  logic [17:0] base;
  logic        done;
  logic [16:0] mm;

  int checks = 0;
  int errors = 0;

  logic        corrupt_on;
  logic [17:0] corrupt_a0;
  logic [17:0] corrupt_a1;
  logic [31:0] sram_pipe [L];

  frame_buffer_reader_if bus();

  frame_buffer_reader #(
    .WIDTH      (W),
    .HEIGHT     (H),
    .RD_LATENCY (L),
    .FIFO_DEPTH (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .pause            (pause),
    .enable           (enable),
    .starting_address (base),
    .bus              (bus),
    .done             (done),
    .mismatch_count   (mm)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sram_word(input logic [17:0] a);
    logic [31:0] w;
    w = {6'd0, a, 8'h00};
    if (corrupt_on && (a == corrupt_a0 || a == corrupt_a1)) w = w ^ 32'h0000_005A;
    return w;
  endfunction

  always @(posedge clk) begin
    sram_pipe[0] <= bus.rden ? sram_word(bus.addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) sram_pipe[i] <= sram_pipe[i-1];
  end

  assign bus.rd_data = sram_pipe[L-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_addr"}, 64'(bus.addr), 0);
    chk({tag, "_rden"}, 64'(bus.rden), 0);
    chk({tag, "_data"}, 64'(bus.pix_data), 0);
    chk({tag, "_valid"}, 64'(bus.pix_valid), 0);
    chk({tag, "_x"}, 64'(bus.pix_x), 0);
    chk({tag, "_y"}, 64'(bus.pix_y), 0);
    chk({tag, "_sof"}, 64'(bus.pix_sof), 0);
    chk({tag, "_eol"}, 64'(bus.pix_eol), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_mm"}, 64'(mm), 0);
  endtask

  // One frame: enable pulse, per-cycle sampling at negedge+1.
  task automatic run_frame(input logic [17:0] b, input bit rnd,
                           input int pause_at, input int abort_at,
                           input bit t_chk, input logic [16:0] exp_mm);
    int hs = 0, reads = 0, c = 0;
    int first_v = -1, first_r = -1, last_c = -1;
    int sofs = 0, eols = 0, max_fl = 0, pause_left = 0;
    bit prev_paused = 0, did_pause = 0, fin = 0, aborted = 0;
    logic [17:0] ea;
    @(negedge clk);
    base   = b;
    enable = 1'b1;
    while (!fin && !aborted && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == 1) enable = 1'b0;
      if (pause_at >= 0 && hs == pause_at && !did_pause) begin
        pause_left = 10;
        did_pause  = 1;
      end
      pause = (pause_left > 0);
      if (pause_left > 0) pause_left--;
      bus.pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_paused) chk("rden_in_pause", 64'(bus.rden), 0);
      if (pause) chk("valid_in_pause", 64'(bus.pix_valid), 0);
      if (bus.rden) begin
        if (first_r < 0) first_r = c;
        ea = b + 18'(reads);
        chk("addr", 64'(bus.addr), 64'(ea));
        reads++;
      end
      if (reads - hs > max_fl) max_fl = reads - hs;
      if (bus.pix_valid && bus.pix_ready) begin
        if (first_v < 0) first_v = c;
        chk("data", 64'(bus.pix_data), 64'(sram_word(b + 18'(hs))));
        chk("x", 64'(bus.pix_x), 64'(hs % W));
        chk("y", 64'(bus.pix_y), 64'(hs / W));
        chk("sof", 64'(bus.pix_sof), 64'(hs == 0));
        chk("eol", 64'(bus.pix_eol), 64'((hs % W) == W - 1));
        sofs += int'(bus.pix_sof);
        eols += int'(bus.pix_eol);
        hs++;
        last_c = c;
        if (hs == TOTAL) fin = 1;
        if (abort_at >= 0 && hs == abort_at) aborted = 1;
      end
      prev_paused = pause;
    end
    pause = 1'b0;
    if (abort_at >= 0) begin
      chk("abort_reached", 64'(hs), 64'(abort_at));
    end else begin
      chk("handshakes", 64'(hs), 64'(TOTAL));
      chk("reads", 64'(reads), 64'(TOTAL));
      chk("sof_count", 64'(sofs), 1);
      chk("eol_count", 64'(eols), 64'(H));
      chk("credit_bound", 64'(max_fl <= D), 1);
      if (t_chk) begin
        chk("first_rden_cycle", 64'(first_r), 2);
        chk("first_valid_cycle", 64'(first_v), 5);
        chk("throughput", 64'(last_c - first_v), 64'(TOTAL - 1));
      end
      @(negedge clk);
      chk("done_after_last", 64'(done), 1);
      chk("mismatch_at_done", 64'(mm), 64'(exp_mm));
      repeat (3) @(negedge clk);
      chk("done_cleared", 64'(done), 0);
    end
  endtask

  initial begin
    reset         = 1'b1;
    pause         = 1'b0;
    enable        = 1'b0;
    base          = '0;
    bus.pix_ready = 1'b0;
    corrupt_on    = 1'b0;
    corrupt_a0    = '0;
    corrupt_a1    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("por");
    @(negedge clk);
    reset = 1'b0;

    // basic frame, full rate, latency and throughput
    run_frame(18'h00000, 1'b0, -1, -1, 1'b1, 17'd0);

    // random backpressure
    run_frame(18'h00100, 1'b1, -1, -1, 1'b0, 17'd0);

    // pause for 10 cycles after 11 pixels (mid-line)
    run_frame(18'h00200, 1'b0, 11, -1, 1'b0, 17'd0);

    // address wrap across 2^18
    run_frame(18'h3FFF0, 1'b0, -1, -1, 1'b0, 17'd0);

    // corrupted words at indices 5 and 20
    corrupt_on = 1'b1;
    corrupt_a0 = 18'h00305;
    corrupt_a1 = 18'h00314;
`ifdef FRAME_READER_CHECK_EN
    run_frame(18'h00300, 1'b0, -1, -1, 1'b0, 17'd2);
`else
    run_frame(18'h00300, 1'b0, -1, -1, 1'b0, 17'd0);
`endif
    corrupt_on = 1'b0;

    // reset mid-frame, then a fresh frame from (0,0)
    run_frame(18'h00000, 1'b0, -1, 10, 1'b0, 17'd0);
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    run_frame(18'h00000, 1'b0, -1, -1, 1'b1, 17'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_buffer_reader.md
# frame_buffer_reader

Scans one full frame out of the 320x240 framebuffer SRAM, starting at a given base address, and presents it as a flow-controlled pixel stream with raster coordinates and frame/line markers. It is the read-side counterpart to the pattern/fill engines that write the framebuffer. It sits between the SRAM arbiter's read port and downstream pixel consumers: display output, UART dump, or the pattern self-check.

## Interface
Parameters:
- WIDTH, 320, pixels per line
- HEIGHT, 240, lines per frame
- RD_LATENCY, 2, edges from SRAM sampling `rden` to `rd_data` being capturable (1..4)
- FIFO_DEPTH, 4, output buffer entries (power of 2, must be >= RD_LATENCY+1)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pause  in  1  stall: no new reads issued, `pix_valid` forced 0
- enable  in  1  start request, level-sensitive, sampled in IDLE
- starting_address  in  18  framebuffer base, held stable while enabled
- rd_data  in  32  SRAM read data
- addr  out  18  SRAM read address
- rden  out  1  SRAM read strobe, one word per cycle high
- pix_data  out  32  pixel word at FIFO head
- pix_valid  out  1  head word available
- pix_ready  in  1  consumer accepts head when high with `pix_valid`
- pix_x  out  9  column of head pixel
- pix_y  out  8  line of head pixel
- pix_sof  out  1  head is pixel (0,0)
- pix_eol  out  1  head is last pixel of a line
- done  out  1  frame fully delivered
- mismatch_count  out  17  pattern errors, saturating (see Configuration)

## Operation
- States: IDLE, READ, DRAIN, DONE, CLEANUP.
- IDLE: outputs at reset values. `enable`=1 and `pause`=0 -> READ. Issue index and output counters cleared.
- READ: each cycle with `pause`=0 and credit available, drive `rden`=1 and `addr`=starting_address+issue_idx (18-bit, modulo 2^18 wrap), then increment issue_idx.
  - credit = outstanding reads + FIFO occupancy < FIFO_DEPTH.
  - After WIDTH*HEIGHT reads, go to DRAIN.
- Return path: a RD_LATENCY-deep valid shift register tracks outstanding reads. Matching `rd_data` is pushed into the FIFO on the capture edge. The FIFO cannot overflow by construction of the credit rule.
- Output: the FIFO is first-word-fall-through. A handshake (`pix_valid`&&`pix_ready`) pops the head and advances the x/y counters:
  - x wraps at WIDTH-1, then y increments.
  - `pix_sof`=(x==0&&y==0); `pix_eol`=(x==WIDTH-1).
- DRAIN: no reads. When the final pixel (WIDTH*HEIGHT-th) handshakes, go to DONE.
- DONE: `done`=1 for one cycle, -> CLEANUP.
- CLEANUP: `done` held 1 while `enable`=1. On `enable`=0: `done`=0, -> IDLE.
- `enable` deasserted mid-frame is ignored; the frame completes.
- `pause` does not cancel in-flight reads; their data still lands in the FIFO. It only blocks issue and output.
- Reset mid-frame: FIFO, pipeline valids and counters cleared. Late `rd_data` is discarded.

## Timing
- Reset values: `addr`=0, `rden`=0, `pix_data`=0, `pix_valid`=0, `pix_x`=0, `pix_y`=0, `pix_sof`=0, `pix_eol`=0, `done`=0, `mismatch_count`=0.
- All outputs are registered, except `pix_*`, which are driven from FIFO head registers.
- Sequence with `enable` sampled at edge 0:
  - state=READ after edge 0.
  - first `rden`/`addr` valid after edge 1.
  - capture at edge 1+RD_LATENCY+1.
  - `pix_valid` high after that edge (RD_LATENCY=2: after edge 4).
- With `pix_ready` held 1 and `pause`=0, throughput is one pixel per cycle. The frame occupies WIDTH*HEIGHT consecutive handshake cycles.
- `done` rises the edge after the final handshake.
- Simultaneous FIFO push and pop in one cycle: occupancy unchanged.

## Configuration
- `FRAME_READER_CHECK_EN` defined:
  - Each popped word at frame index i is compared with expected {zero-extended (starting_address+i) to 24 bits, 8'h00}.
  - Each mismatch increments `mismatch_count`, saturating at 17'h1FFFF.
  - Counter clears on leaving IDLE and holds through DONE and CLEANUP.
- Not defined: compare logic absent, `mismatch_count` tied to 0. The port is always present.

## Test plan
- Basic frame: model SRAM returns the expected gradient, RD_LATENCY=2, `pix_ready`=1, base 0, `enable` pulse -> 76800 handshakes, and:
  - `pix_sof` on the first only; `pix_eol` 240 times.
  - last handshake has x=319, y=239.
  - `done`=1 the next cycle; `mismatch_count`=0.
- Backpressure: `pix_ready` random 50% -> no lost or duplicated words; `rden` never high when outstanding+occupancy=4; same data order.
- Pause: assert `pause` for 10 cycles mid-line -> `rden`=0 and `pix_valid`=0 during the pause; in-flight words are delivered afterwards; pixel sequence contiguous.
- Address wrap: base 18'h3FFF0 -> `addr` sequence ...3FFFF, 00000, 00001...; 76800 pixels delivered; `done` asserted.
- Check enabled: corrupt words at indices 5 and 1000 -> `mismatch_count`=2 at `done`.
- Reset mid-frame: `reset` at pixel 500 -> all outputs return to reset values immediately. Re-enable -> a fresh frame starts at x=0, y=0 with `pix_sof`=1.
